// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the two-port memory arbiter
package mem_arb_pkg;

    localparam int AW_DEFAULT = 10;
    localparam int DW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } state_t;

endpackage

// File: rtl/arb_pick2.sv
// rtl/arb_pick2.sv - two-way winner select; MEM_ARB_FIXED_PRIO_EN makes requester 0 win every tie
module arb_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_id,
    output logic win_id,
    output logic any
);

    assign any = req0 | req1;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign win_id = ~req0 & req1;
`else
    // On a tie the requester that was not served last goes next.
    assign win_id = (req0 & req1) ? ~last_id : req1;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-port memory arbiter; tie policy set by MEM_ARB_FIXED_PRIO_EN
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          mem_rd_en,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    state_t        state_q, state_d;
    logic          last_id_q, last_id_d;
    logic          cmd_we_q, cmd_we_d;
    logic          cmd_id_q, cmd_id_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic          mem_rd_en_q, mem_rd_en_d;
    logic          mem_wr_en_q, mem_wr_en_d;

    logic win_id;
    logic any_req;
    logic win_we;

    arb_pick2 u_pick (
        .req0    (req0),
        .req1    (req1),
        .last_id (last_id_q),
        .win_id  (win_id),
        .any     (any_req)
    );

    assign win_we = win_id ? we1 : we0;

    // The latched command doubles as the memory command registers, so ACCESS
    // outputs appear on the cycle right after the request is sampled.
    always_comb begin
        state_d     = state_q;
        last_id_d   = last_id_q;
        cmd_we_d    = cmd_we_q;
        cmd_id_d    = cmd_id_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        mem_rd_en_d = 1'b0;
        mem_wr_en_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d     = ACCESS;
                    cmd_id_d    = win_id;
                    cmd_we_d    = win_we;
                    mem_addr_d  = win_id ? addr1 : addr0;
                    mem_din_d   = win_id ? wdata1 : wdata0;
                    gnt0_d      = ~win_id;
                    gnt1_d      = win_id;
                    mem_wr_en_d = win_we;
                    mem_rd_en_d = ~win_we;
                end
            end
            ACCESS: begin
                last_id_d = cmd_id_q;
                if (cmd_we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d   = RDWAIT;
                    rvalid0_d = ~cmd_id_q;
                    rvalid1_d = cmd_id_q;
                end
            end
            RDWAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            last_id_q   <= 1'b1;
            cmd_we_q    <= 1'b0;
            cmd_id_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_id_q   <= last_id_d;
            cmd_we_q    <= cmd_we_d;
            cmd_id_q    <= cmd_id_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_wr_en_q <= mem_wr_en_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    // Memory output is already registered one cycle after mem_rd_en, so pass it straight through.
    assign rdata     = (state_q == RDWAIT) ? mem_dout : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transaction-level reference model
module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] tb_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [int];
    logic [AW-1:0] written [$];
    bit            grant_log [$];
    bit            last_won;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) tb_mem[mem_addr] <= mem_din;
        if (mem_rd_en) mem_dout <= tb_mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            chk("both_mem_en", 32'(mem_rd_en & mem_wr_en), 32'd0);
            chk("both_gnt", 32'(gnt0 & gnt1), 32'd0);
            chk("both_rvalid", 32'(rvalid0 & rvalid1), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, 32'({gnt0, gnt1, rvalid0, rvalid1, mem_rd_en, mem_wr_en}), 32'd0);
    endtask

    task automatic set_cmd(input bit id, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!id) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic new_cmd(input bit id);
        bit            we;
        logic [AW-1:0] a;
        we = (written.size() == 0) || ($urandom_range(0, 1) == 1);
        if (we) a = AW'($urandom_range(0, 31));
        else    a = written[$urandom_range(0, written.size() - 1)];
        set_cmd(id, we, a, DW'($urandom));
    endtask

    // One arbitration round from IDLE: predict winner, check grant/memory/read-back, return in IDLE.
    task automatic serve(input bit drop);
        bit            w;
        bit            we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            w = 1'b0;
`else
            w = ~last_won;
`endif
        end else begin
            w = req1;
        end
        we = w ? we1 : we0;
        a  = w ? addr1 : addr0;
        d  = w ? wdata1 : wdata0;
        tick();
        chk("gnt0", 32'(gnt0), 32'(!w));
        chk("gnt1", 32'(gnt1), 32'(w));
        chk("mem_wr_en", 32'(mem_wr_en), 32'(we));
        chk("mem_rd_en", 32'(mem_rd_en), 32'(!we));
        chk("mem_addr", 32'(mem_addr), 32'(a));
        if (we) chk("mem_din", 32'(mem_din), 32'(d));
        if (gnt0 || gnt1) grant_log.push_back(gnt1);
        last_won = w;
        if (we) begin
            ref_mem[int'(a)] = d;
            written.push_back(a);
        end
        if (drop) begin
            if (w) req1 = 1'b0; else req0 = 1'b0;
        end else begin
            set_cmd(w, we, AW'(256 + $urandom_range(0, 255)), DW'($urandom));
        end
        tick();
        if (!we) begin
            chk("rvalid0", 32'(rvalid0), 32'(!w));
            chk("rvalid1", 32'(rvalid1), 32'(w));
            chk("rd_gnt_off", 32'({gnt0, gnt1, mem_rd_en, mem_wr_en}), 32'd0);
            if (ref_mem.exists(int'(a))) chk("rdata", 32'(rdata), 32'(ref_mem[int'(a)]));
            tick();
        end
        chk_quiet("idle_after_access");
    endtask

    initial begin
        rstn = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        last_won = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_quiet("reset_ctrl");
        chk("reset_addr", 32'(mem_addr), 32'd0);
        chk("reset_din", 32'(mem_din), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        rstn = 1'b1;
        tick();
        chk_quiet("idle_no_req");

        // Reset asserted while the read sits in RDWAIT.
        set_cmd(0, 1'b0, 10'h3FF, 8'h00);
        tick();
        chk("abort_gnt0", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk_quiet("abort_ctrl");
        chk("abort_addr", 32'(mem_addr), 32'd0);
        chk("abort_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        last_won = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet("after_abort");
        end

        // Single write, then read-back from the other requester.
        set_cmd(0, 1'b1, 10'h3FF, 8'hA5);
        serve(1);
        set_cmd(1, 1'b0, 10'h3FF, 8'h00);
        serve(1);
        chk("readback_order", 32'(grant_log[grant_log.size() - 1]), 32'd1);

        // Continuous tie with writes.
        grant_log.delete();
        set_cmd(0, 1'b1, 10'h100, 8'h11);
        set_cmd(1, 1'b1, 10'h101, 8'h22);
        for (int k = 0; k < 4; k++) serve(0);
        req0 = 1'b0;
        req1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            chk($sformatf("tie_order_%0d", k), 32'(grant_log[k]), 32'd0);
`else
            chk($sformatf("tie_order_%0d", k), 32'(grant_log[k]), 32'(k % 2));
`endif
        end
        chk("tie_count", 32'(grant_log.size()), 32'd4);
        tick();
        chk_quiet("tie_drained");

        // Mixed read/write contention.
        set_cmd(1, 1'b1, 10'h010, 8'h5C);
        serve(1);
        grant_log.delete();
        set_cmd(0, 1'b0, 10'h010, 8'h00);
        set_cmd(1, 1'b1, 10'h020, 8'hC3);
        serve(1);
        serve(1);
        chk("mixed_first", 32'(grant_log[0]), 32'd0);
        chk("mixed_second", 32'(grant_log[1]), 32'd1);

        // Randomized traffic; a losing requester keeps its command until granted.
        for (int i = 0; i < 60; i++) begin
            if (!req0 && !req1 && $urandom_range(0, 3) == 0) begin
                addr0 = AW'($urandom);
                wdata0 = DW'($urandom);
                tick();
                chk_quiet("rand_idle");
                continue;
            end
            if (!req0 && $urandom_range(0, 1) == 1) new_cmd(0);
            if (!req1 && $urandom_range(0, 1) == 1) new_cmd(1);
            if (!req0 && !req1) new_cmd(0);
            serve(1);
        end
        for (int i = 0; i < 2; i++) if (req0 || req1) serve(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 10, memory address width.
REQ-002 Parameter DW, default 8, memory data width.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 req0/req1  input  1 each  access request from requester 0/1.
REQ-006 we0/we1  input  1 each  1 = write, 0 = read; qualified by reqN.
REQ-007 addr0/addr1  input  AW each  access address.
REQ-008 wdata0/wdata1  input  DW each  write data.
REQ-009 gnt0/gnt1  output  1 each  one-cycle pulse: command accepted and issued to memory.
REQ-010 rvalid0/rvalid1  output  1 each  one-cycle pulse: rdata valid for that requester.
REQ-011 rdata  output  DW  read data; shared by both requesters, qualified by rvalidN.
REQ-012 mem_rd_en/mem_wr_en  output  1 each  memory enables; never both high.
REQ-013 mem_addr  output  AW  memory address.
REQ-014 mem_din  output  DW  memory write data.
REQ-015 mem_dout  input  DW  memory read data, registered in memory, valid one cycle after mem_rd_en.

Function
REQ-016 FSM states: IDLE, ACCESS, RDWAIT; exactly one state active.
REQ-017 IDLE: when any reqN is high at a clock edge, pick the winner, latch its we/addr/wdata and id into internal registers, and go to ACCESS; otherwise stay in IDLE.
REQ-018 Winner selection: only one reqN high -> that requester; both high -> requester that was not granted last (round robin); last_id resets to 1, so requester 0 wins the first tie.
REQ-019 ACCESS, one cycle: drive mem_addr/mem_din from the latched command, mem_wr_en=we and mem_rd_en=~we, pulse gntN for the winner, update last_id; next state RDWAIT if read, IDLE if write.
REQ-020 RDWAIT, one cycle: rdata = mem_dout, rvalidN pulses for the latched id; next state IDLE.
REQ-021 Latency from req sampled: write gnt at +1 cycle; read gnt at +1 and rvalid at +2; new request accepted no earlier than IDLE re-entry.
REQ-022 Requesters hold req/we/addr/wdata until gnt; changes after latching do not affect the issued command; req deasserted before sampling -> no access.
REQ-023 Outside ACCESS: mem_rd_en=mem_wr_en=0. Outside RDWAIT: all rvalidN=0. Outside ACCESS: all gntN=0.
REQ-024 At most one gntN and at most one rvalidN high in any cycle.

Reset
REQ-025 rstn low forces immediately: state=IDLE, last_id=1, latched command cleared, all gnt/rvalid/mem enables=0, mem_addr=0, mem_din=0, rdata=0.
REQ-026 Reset during ACCESS or RDWAIT aborts the access; no gnt or rvalid issues for it after reset release.

Configuration
REQ-027 Macro MEM_ARB_FIXED_PRIO_EN defined: on a tie, requester 0 always wins and last_id is unused. Macro undefined: round robin per REQ-018.

Structure
REQ-028 Package mem_arb_pkg holds the state enum (IDLE/ACCESS/RDWAIT) and the AW/DW default constants.
REQ-029 Sub-module arb_pick2 does combinational winner selection (inputs req0, req1, last_id; output win_id, any); it is the only place affected by MEM_ARB_FIXED_PRIO_EN.

Verification
REQ-030 Reset: rstn=0 mid-read in RDWAIT -> rvalid0 stays 0, all outputs 0, state IDLE after release.
REQ-031 Single write: req0=1, we0=1, addr0=0x3FF, wdata0=0xA5 -> gnt0 and mem_wr_en at +1, mem_addr=0x3FF, mem_din=0xA5; back in IDLE at +2.
REQ-032 Read-back: req1 read addr 0x3FF after the write -> gnt1 at +1, rvalid1 at +2 with rdata=0xA5.
REQ-033 Tie: req0=req1=1 held continuously, alternating writes -> grant order 0,1,0,1; with MEM_ARB_FIXED_PRIO_EN defined -> 0,0,0,0.
REQ-034 Mixed: req0 read 0x010 and req1 write 0x020 together -> only one mem enable high per cycle, never both; gnt0 then rvalid0, then gnt1.
